// File: rtl/vga_pkg.sv
// Shared raster timing constants and coordinate type for the VGA timing generator.
// Defaults describe 640x480@60; blocks override them through parameters.
package vga_pkg;
    localparam int COORD_W = 10;
    typedef logic [COORD_W-1:0] coord_t;

    localparam int DEF_H_VISIBLE = 640;
    localparam int DEF_H_FRONT   = 16;
    localparam int DEF_H_SYNC    = 96;
    localparam int DEF_H_BACK    = 48;
    localparam int DEF_V_VISIBLE = 480;
    localparam int DEF_V_FRONT   = 10;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_BACK    = 33;

    localparam int DEF_H_TOTAL = DEF_H_VISIBLE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
    localparam int DEF_V_TOTAL = DEF_V_VISIBLE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

    function automatic logic in_window(input coord_t v, input coord_t lo, input coord_t hi);
        return (v >= lo) && (v < hi);
    endfunction
endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping counter plus registered sync window decoded from the next count.
// vis_nxt_o is the visible-area compare on the next count so the parent can register it in step.
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int VISIBLE = DEF_H_VISIBLE,
    parameter int FRONT   = DEF_H_FRONT,
    parameter int SYNC    = DEF_H_SYNC,
    parameter int BACK    = DEF_H_BACK
) (
    input  logic   clk_i,
    input  logic   rst_i,
    input  logic   clr_i,
    input  logic   inc_i,
    output coord_t cnt_o,
    output logic   wrap_o,
    output logic   sync_o,
    output logic   vis_nxt_o
);
    localparam int     TOTAL   = VISIBLE + FRONT + SYNC + BACK;
    localparam coord_t LAST    = coord_t'(TOTAL - 1);
    localparam coord_t SYNC_LO = coord_t'(VISIBLE + FRONT);
    localparam coord_t SYNC_HI = coord_t'(VISIBLE + FRONT + SYNC);
    localparam coord_t VIS_END = coord_t'(VISIBLE);

    coord_t cnt_q, cnt_d;
    logic   sync_q, sync_d;

    always_comb begin
        wrap_o = inc_i && (cnt_q == LAST);
        cnt_d  = cnt_q;
        if (clr_i || wrap_o) begin
            cnt_d = '0;
        end else if (inc_i) begin
            cnt_d = cnt_q + coord_t'(1);
        end
        sync_d    = !clr_i && in_window(cnt_d, SYNC_LO, SYNC_HI);
        vis_nxt_o = cnt_d < VIS_END;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q  <= '0;
            sync_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            sync_q <= sync_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign sync_o = sync_q;
endmodule

// File: rtl/vga_timing_gen.sv
// Programmable VGA raster timing: pixel divider, x/y counters, polarity-mapped syncs,
// visible flag, line/frame strobes, frame counter and sticky vblank interrupt.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_VISIBLE = DEF_H_VISIBLE,
    parameter int H_FRONT   = DEF_H_FRONT,
    parameter int H_SYNC    = DEF_H_SYNC,
    parameter int H_BACK    = DEF_H_BACK,
    parameter int V_VISIBLE = DEF_V_VISIBLE,
    parameter int V_FRONT   = DEF_V_FRONT,
    parameter int V_SYNC    = DEF_V_SYNC,
    parameter int V_BACK    = DEF_V_BACK,
    parameter int PIX_DIV   = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       polarity,
    input  logic       irq_clr,
    output logic       hsync,
    output logic       vsync,
    output logic       visible,
    output logic [9:0] pix_x,
    output logic [9:0] pix_y,
    output logic       line_start,
    output logic       frame_start,
    output logic [7:0] frame_count,
    output logic       vblank_irq
);
    localparam int                 DIV_W    = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
    localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(PIX_DIV - 1);
    localparam coord_t             Y_PRE_VB = coord_t'(V_VISIBLE - 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic             run_q;
    logic             start, clr, adv;
    logic             x_wrap, y_wrap, hs_int, vs_int, x_vis_nxt, y_vis_nxt;
    coord_t           x_cnt, y_cnt;
    logic             visible_q, visible_d;
    logic             line_start_q, line_start_d;
    logic             frame_start_q, frame_start_d;
    logic [7:0]       frame_count_q, frame_count_d;
    logic             irq_q, irq_d;

    vga_axis_counter #(
        .VISIBLE(H_VISIBLE), .FRONT(H_FRONT), .SYNC(H_SYNC), .BACK(H_BACK)
    ) u_h (
        .clk_i(clk), .rst_i(reset), .clr_i(clr), .inc_i(adv),
        .cnt_o(x_cnt), .wrap_o(x_wrap), .sync_o(hs_int), .vis_nxt_o(x_vis_nxt)
    );

    vga_axis_counter #(
        .VISIBLE(V_VISIBLE), .FRONT(V_FRONT), .SYNC(V_SYNC), .BACK(V_BACK)
    ) u_v (
        .clk_i(clk), .rst_i(reset), .clr_i(clr), .inc_i(x_wrap),
        .cnt_o(y_cnt), .wrap_o(y_wrap), .sync_o(vs_int), .vis_nxt_o(y_vis_nxt)
    );

    // The first enabled edge parks the raster on (0,0) instead of advancing,
    // so the origin pixel is shown for a full pixel period with both strobes.
    always_comb begin
        start         = enable && !run_q;
        clr           = !enable || start;
        adv           = enable && !start && (div_q == DIV_LAST);
        div_d         = (clr || adv) ? '0 : div_q + DIV_W'(1);
        visible_d     = enable && x_vis_nxt && y_vis_nxt;
        line_start_d  = start || x_wrap;
        frame_start_d = start || y_wrap;
        frame_count_d = frame_count_q + (y_wrap ? 8'd1 : 8'd0);
        irq_d         = irq_q;
        if (x_wrap && (y_cnt == Y_PRE_VB)) begin
            irq_d = 1'b1;
        end else if (irq_clr) begin
            irq_d = 1'b0;
        end
    end

    // run_q resets high: leaving reset counts as already sitting at the origin.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_q         <= '0;
            run_q         <= 1'b1;
            visible_q     <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            frame_count_q <= 8'd0;
            irq_q         <= 1'b0;
        end else begin
            div_q         <= div_d;
            run_q         <= enable;
            visible_q     <= visible_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
            frame_count_q <= frame_count_d;
            irq_q         <= irq_d;
        end
    end

    assign hsync       = polarity ? hs_int : ~hs_int;
    assign vsync       = polarity ? vs_int : ~vs_int;
    assign visible     = visible_q;
    assign pix_x       = x_cnt;
    assign pix_y       = y_cnt;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;
    assign frame_count = frame_count_q;
    assign vblank_irq  = irq_q;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench on a shrunken raster (16x10 totals) with PIX_DIV=1 and PIX_DIV=2 instances.
module tb_vga_timing_gen;
    logic       clk = 1'b0;
    logic       reset, enable, polarity, irq_clr;
    logic       hs1, vs1, vis1, ls1, fs1, irq1;
    logic [9:0] x1, y1;
    logic [7:0] fc1;
    logic       hs2, vs2, vis2, ls2, fs2, irq2;
    logic [9:0] x2, y2;
    logic [7:0] fc2;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    vga_timing_gen #(
        .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
        .V_VISIBLE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1), .PIX_DIV(1)
    ) u_dut1 (
        .clk(clk), .reset(reset), .enable(enable), .polarity(polarity), .irq_clr(irq_clr),
        .hsync(hs1), .vsync(vs1), .visible(vis1), .pix_x(x1), .pix_y(y1),
        .line_start(ls1), .frame_start(fs1), .frame_count(fc1), .vblank_irq(irq1)
    );

    vga_timing_gen #(
        .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
        .V_VISIBLE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1), .PIX_DIV(2)
    ) u_dut2 (
        .clk(clk), .reset(reset), .enable(enable), .polarity(polarity), .irq_clr(irq_clr),
        .hsync(hs2), .vsync(vs2), .visible(vis2), .pix_x(x2), .pix_y(y2),
        .line_start(ls2), .frame_start(fs2), .frame_count(fc2), .vblank_irq(irq2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int  ex, ey, vis_cnt;
        logic hsi, vsi, pol, m_irq;

        reset = 1'b1; enable = 1'b0; polarity = 1'b0; irq_clr = 1'b0;
        tick(); tick();
        check("rst_x", x1, 0);
        check("rst_y", y1, 0);
        check("rst_hs", hs1, 1);
        check("rst_vs", vs1, 1);
        check("rst_vis", vis1, 0);
        check("rst_ls", ls1, 0);
        check("rst_fs", fs1, 0);
        check("rst_fc", fc1, 0);
        check("rst_irq", irq1, 0);

        reset = 1'b0;
        tick(); tick();
        check("dis_x", x1, 0);
        check("dis_vis", vis1, 0);
        check("dis_hs", hs1, 1);

        enable = 1'b1;
        tick();
        m_irq = 1'b0; vis_cnt = 0;
        for (int n = 0; n < 480; n++) begin
            ex  = n % 16;
            ey  = (n / 16) % 10;
            hsi = (ex >= 10) && (ex < 13);
            vsi = (ey >= 7) && (ey < 9);
            pol = (n >= 320);
            if (n % 160 == 96) m_irq = 1'b1;
            else if (n == 121) m_irq = 1'b0;
            if (n < 160) vis_cnt += int'(vis1);
            check("x", x1, ex);
            check("y", y1, ey);
            check("hsync", hs1, pol ? hsi : !hsi);
            check("vsync", vs1, pol ? vsi : !vsi);
            check("visible", vis1, (ex < 8) && (ey < 6));
            check("line_start", ls1, ex == 0);
            check("frame_start", fs1, (ex == 0) && (ey == 0));
            check("frame_count", fc1, n / 160);
            check("irq", irq1, m_irq);
            check("x_div2", x2, (n / 2) % 16);
            check("y_div2", y2, (n / 32) % 10);
            check("ls_div2", ls2, n % 32 == 0);
            check("fs_div2", fs2, n % 320 == 0);
            irq_clr = (n == 95) || (n == 120);
            if (n == 319) begin
                polarity = 1'b1;
                #1;
                check("pol_hs_comb", hs1, 0);
                check("pol_vs_comb", vs1, 0);
                check("pol_x_kept", x1, 15);
            end
            tick();
        end
        irq_clr = 1'b0;
        check("vis_per_frame", vis_cnt, 48);

        repeat (5) tick();
        check("mid_x", x1, 5);
        enable = 1'b0;
        tick();
        check("off_x", x1, 0);
        check("off_y", y1, 0);
        check("off_vis", vis1, 0);
        check("off_hs", hs1, 0);
        check("off_ls", ls1, 0);
        check("off_fs", fs1, 0);
        check("off_fc", fc1, 3);
        check("off_irq", irq1, 1);
        check("off_x2", x2, 0);
        tick();
        check("off2_x", x1, 0);
        enable = 1'b1;
        tick();
        check("on_x", x1, 0);
        check("on_y", y1, 0);
        check("on_fs", fs1, 1);
        check("on_ls", ls1, 1);
        check("on_vis", vis1, 1);
        tick();
        check("on1_x", x1, 1);
        check("on1_fs", fs1, 0);

        for (int i = 0; i < 40319; i++) tick();
        check("fc_255", fc1, 255);
        check("fc_255_fs", fs1, 1);
        check("fc_255_x", x1, 0);
        repeat (160) tick();
        check("fc_wrap", fc1, 0);
        check("fc_wrap_fs", fs1, 1);

        repeat (53) tick();
        check("pre_rst_x", x1, 5);
        check("pre_rst_y", y1, 3);
        check("pre_rst_vis", vis1, 1);
        reset = 1'b1;
        #1;
        check("arst_x", x1, 0);
        check("arst_y", y1, 0);
        check("arst_vis", vis1, 0);
        check("arst_hs", hs1, 0);
        check("arst_vs", vs1, 0);
        check("arst_fc", fc1, 0);
        check("arst_irq", irq1, 0);
        reset = 1'b0;
        tick();
        check("post_rst_x", x1, 1);
        check("post_rst_fs", fs1, 0);
        check("post_rst_ls", ls1, 0);
        check("post_rst_vis", vis1, 1);
        check("post_rst_x2", x2, 0);
        tick();
        check("post_rst_x2b", x2, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
